// File: rtl/clk_encoded_tx.sv
// Manchester transmitter for the clock-encoded-data link: a preamble of encoded
// ones, then MSB-first words at a programmable half-bit period.
package common_p;
   typedef struct packed {
      logic clk;
      logic rst;
   } clk_dom_s;
endpackage

module clk_encoded_tx #(
   parameter int RATE_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int PREAMBLE_BITS = 8
) (
   input  common_p::clk_dom_s    sys_dom_i,
   input  logic                  tx_en_i,
   input  logic [RATE_WIDTH-1:0] half_period_i,
   input  logic                  polarity_i,
   input  logic                  idle_level_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  data_valid_i,
   output logic                  data_ready_o,
   output logic                  io_clk_o,
   output logic                  tx_active_o,
   output logic                  mid_bit_o,
   output logic                  frame_done_o,
   output logic                  aborted_o
);
   localparam int MAX_BITS = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
   localparam int BW       = $clog2(MAX_BITS + 1);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

   logic                  clk;
   logic                  rst;
   state_t                state;
   logic [RATE_WIDTH-1:0] half_len;
   logic [RATE_WIDTH-1:0] cnt;
   logic                  pol;
   logic                  second_half;
   logic [BW-1:0]         bits_left;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_valid;
   logic                  hold_valid_nxt;
   logic                  accept;
   logic                  boundary;
   logic                  last_bit;
   logic                  load;
   logic                  clear;
   logic                  next_bit;

   assign clk = sys_dom_i.clk;
   assign rst = sys_dom_i.rst;

   assign accept     = data_valid_i && data_ready_o;
   assign boundary   = (state != IDLE) && second_half && (cnt == '0);
   assign last_bit   = (bits_left == '0);
   assign load       = boundary && tx_en_i && last_bit && ((state == PREAMBLE) || hold_valid);
   assign clear      = load || (boundary && !tx_en_i);
   assign shreg_next = shreg << 1;
   assign next_bit   = (state == PREAMBLE) ? 1'b1 : shreg_next[DATA_WIDTH-1];

   // Ready is registered from the next hold state so a full register never re-accepts.
   always_comb begin
      hold_valid_nxt = hold_valid;
      if (clear)  hold_valid_nxt = 1'b0;
      if (accept) hold_valid_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid   <= 1'b0;
         hold_data    <= '0;
         data_ready_o <= 1'b0;
      end else begin
         hold_valid   <= hold_valid_nxt;
         data_ready_o <= tx_en_i && !hold_valid_nxt;
         if (accept) hold_data <= data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         half_len     <= '0;
         cnt          <= '0;
         pol          <= 1'b0;
         second_half  <= 1'b0;
         bits_left    <= '0;
         shreg        <= '0;
         io_clk_o     <= 1'b0;
         tx_active_o  <= 1'b0;
         mid_bit_o    <= 1'b0;
         frame_done_o <= 1'b0;
         aborted_o    <= 1'b0;
      end else begin
         mid_bit_o    <= 1'b0;
         frame_done_o <= 1'b0;
         aborted_o    <= 1'b0;
         unique case (state)
            IDLE: begin
               io_clk_o <= idle_level_i;
               if (tx_en_i && hold_valid) begin
                  state       <= PREAMBLE;
                  half_len    <= (half_period_i == '0) ? RATE_WIDTH'(1) : half_period_i;
                  cnt         <= (half_period_i == '0) ? '0 : half_period_i - 1'b1;
                  pol         <= polarity_i;
                  second_half <= 1'b0;
                  bits_left   <= BW'(PREAMBLE_BITS - 1);
                  io_clk_o    <= polarity_i;
                  tx_active_o <= 1'b1;
               end
            end
            default: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!second_half) begin
                  // Second half is always the complement of the first.
                  cnt         <= half_len - 1'b1;
                  second_half <= 1'b1;
                  mid_bit_o   <= 1'b1;
                  io_clk_o    <= ~io_clk_o;
               end else if (!tx_en_i) begin
                  state        <= IDLE;
                  io_clk_o     <= idle_level_i;
                  tx_active_o  <= 1'b0;
                  frame_done_o <= 1'b1;
                  aborted_o    <= 1'b1;
               end else if (!last_bit) begin
                  bits_left   <= bits_left - 1'b1;
                  if (state == DATA) shreg <= shreg_next;
                  cnt         <= half_len - 1'b1;
                  second_half <= 1'b0;
                  io_clk_o    <= ~(next_bit ^ pol);
               end else if (load) begin
                  state       <= DATA;
                  shreg       <= hold_data;
                  bits_left   <= BW'(DATA_WIDTH - 1);
                  cnt         <= half_len - 1'b1;
                  second_half <= 1'b0;
                  io_clk_o    <= ~(hold_data[DATA_WIDTH-1] ^ pol);
               end else begin
                  state        <= IDLE;
                  io_clk_o     <= idle_level_i;
                  tx_active_o  <= 1'b0;
                  frame_done_o <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule
